// File: rtl/sram_pkg.sv
// Shared definitions for the word-to-byte SRAM controller: FSM states,
// default geometry and the active-low polarity of the SRAM strobes.
package sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int DW_DEFAULT    = 32;
    localparam int BYTES_DEFAULT = DW_DEFAULT / 8;

    // SRAM strobes are active low.
    localparam logic CTL_ON  = 1'b0;
    localparam logic CTL_OFF = 1'b1;

    // Beat counter width; at least one bit even for a single-byte word.
    function automatic int beat_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

    localparam int BEAT_W_DEFAULT = beat_width(BYTES_DEFAULT);

endpackage

// File: rtl/sram_word_ctrl.sv
// Word-wide request port serialised into little-endian single-cycle byte
// accesses on a 32Kx8 asynchronous SRAM. All SRAM-facing outputs are
// registered; the value for each beat is computed one cycle ahead so the
// first beat appears in the cycle right after the request is accepted.
module sram_word_ctrl
    import sram_pkg::*;
#(
    parameter int  DW    = 32,
    parameter int  AW    = 15,
    localparam int BYTES = DW / 8,
    localparam int WAW   = AW - $clog2(DW / 8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [WAW-1:0]   req_addr,
    input  logic [DW-1:0]    req_wdata,
    input  logic [BYTES-1:0] req_wstrb,
    output logic             rsp_valid,
    output logic [DW-1:0]    rsp_rdata,
    output logic             sram_ce_n,
    output logic             sram_oe_n,
    output logic             sram_we_n,
    output logic [AW-1:0]    sram_a,
    output logic [7:0]       io_out,
    output logic             io_oe,
    input  logic [7:0]       io_in
);

    localparam int AS = $clog2(BYTES);        // byte-lane bits inside a word
    localparam int BW = beat_width(BYTES);    // beat counter width

    state_t             state_reg, state_next;
    logic [BW-1:0]      beat_reg, beat_next;

    // Request captured on accept; the requester may change req_* afterwards.
    logic               we_q;
    logic [WAW-1:0]     addr_q;
    logic [DW-1:0]      wdata_q;
    logic [BYTES-1:0]   wstrb_q;

    logic [DW-1:0]      rdata_q, rdata_merged, rsp_rdata_reg;

    logic               ce_reg, oe_reg, we_reg, io_oe_reg, rsp_valid_reg;
    logic               ce_next, oe_next, we_next, io_oe_next, rsp_valid_next;
    logic [AW-1:0]      a_reg, a_next;
    logic [7:0]         io_out_reg, io_out_next;

    // Beat about to be presented and where its request fields come from.
    logic               issue;
    logic [BW-1:0]      issue_beat;
    logic               src_we;
    logic [WAW-1:0]     src_addr;
    logic [DW-1:0]      src_wdata;
    logic [BYTES-1:0]   src_wstrb;

    logic               accept, last_beat;

    assign accept    = req_valid && (state_reg == ST_IDLE);
    assign last_beat = (beat_reg == BW'(BYTES - 1));

    // Next-state logic; also picks which beat (if any) is driven next cycle.
    always_comb begin
        state_next     = state_reg;
        beat_next      = beat_reg;
        rsp_valid_next = 1'b0;
        issue          = 1'b0;
        issue_beat     = '0;
        src_we         = we_q;
        src_addr       = addr_q;
        src_wdata      = wdata_q;
        src_wstrb      = wstrb_q;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    // First beat comes straight from the request inputs
                    // because the capture registers load on this same edge.
                    state_next = ST_ACCESS;
                    beat_next  = '0;
                    issue      = 1'b1;
                    src_we     = req_we;
                    src_addr   = req_addr;
                    src_wdata  = req_wdata;
                    src_wstrb  = req_wstrb;
                end
            end
            ST_ACCESS: begin
                if (last_beat) begin
                    state_next     = ST_RESP;
                    rsp_valid_next = 1'b1;
                end else begin
                    beat_next  = beat_reg + 1'b1;
                    issue      = 1'b1;
                    issue_beat = beat_reg + 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // SRAM strobes, address and byte lane for the beat being issued; all
    // strobes idle otherwise (RESP doubles as the deselect/turnaround cycle).
    always_comb begin
        ce_next     = CTL_OFF;
        oe_next     = CTL_OFF;
        we_next     = CTL_OFF;
        io_oe_next  = 1'b0;
        io_out_next = 8'h00;
        a_next      = a_reg;
        if (issue) begin
            a_next = (AW'(src_addr) << AS) | AW'(issue_beat);
            if (src_we) begin
                // Masked lanes still consume a beat so timing never varies.
                if (src_wstrb[issue_beat]) begin
                    ce_next     = CTL_ON;
                    we_next     = CTL_ON;
                    io_oe_next  = 1'b1;
                    io_out_next = src_wdata[8*issue_beat +: 8];
                end
            end else begin
                ce_next = CTL_ON;
                oe_next = CTL_ON;
            end
        end
    end

    // Current read beat's byte merged into the partially assembled word.
    always_comb begin
        rdata_merged = rdata_q;
        rdata_merged[8*beat_reg +: 8] = io_in;
    end

    // FSM state, beat counter and registered SRAM-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            beat_reg      <= '0;
            ce_reg        <= CTL_OFF;
            oe_reg        <= CTL_OFF;
            we_reg        <= CTL_OFF;
            io_oe_reg     <= 1'b0;
            io_out_reg    <= 8'h00;
            a_reg         <= '0;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            beat_reg      <= beat_next;
            ce_reg        <= ce_next;
            oe_reg        <= oe_next;
            we_reg        <= we_next;
            io_oe_reg     <= io_oe_next;
            io_out_reg    <= io_out_next;
            a_reg         <= a_next;
            rsp_valid_reg <= rsp_valid_next;
        end
    end

    // Request capture on accept and read-data assembly; the response word
    // only changes when a read finishes so it stays stable between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rdata_q       <= '0;
            rsp_rdata_reg <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
            if (state_reg == ST_ACCESS && !we_q) begin
                rdata_q <= rdata_merged;
                if (last_beat) begin
                    rsp_rdata_reg <= rdata_merged;
                end
            end
        end
    end

    assign req_ready = (state_reg == ST_IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign sram_ce_n = ce_reg;
    assign sram_oe_n = oe_reg;
    assign sram_we_n = we_reg;
    assign sram_a    = a_reg;
    assign io_out    = io_out_reg;
    assign io_oe     = io_oe_reg;

endmodule

// File: doc/sram_word_ctrl.md
Name: sram_word_ctrl

Overview:
- Initiator-side controller for the 32Kx8 asynchronous SRAM bus (active-low CE/OE/WE, 15-bit address, 8-bit bidirectional data).
- Accepts word-wide read/write requests from the core/bus side and serialises each one into DW/8 single-cycle byte accesses, little-endian.
- Sits between the RISC-V load/store path and the SRAM device.
- The tristate data pad is resolved at top level from io_out/io_oe.

Parameters:
- DW, 32, request data width; must be a multiple of 8; BYTES = DW/8.
- AW, 15, SRAM byte-address width.
- WAW, AW - clog2(DW/8) (13 at defaults), request word-address width; derived, not overridable.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  WAW  word address.
- req_wdata  in  DW  write data.
- req_wstrb  in  BYTES  byte write enables.
- rsp_valid  out  1  one-cycle completion pulse, for both reads and writes.
- rsp_rdata  out  DW  read data; valid when rsp_valid and the transaction was a read.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_a  out  AW  byte address.
- io_out  out  8  data driven to SRAM.
- io_oe  out  1  pad drive enable, active high.
- io_in  in  8  data sampled from SRAM.

Behaviour:
Reset:
- Async assert forces state IDLE.
- sram_ce_n = sram_oe_n = sram_we_n = 1; io_oe = 0; io_out = 0; sram_a = 0.
- rsp_valid = 0; rsp_rdata = 0; req_ready = 1 after release.
- Reset mid-transaction aborts immediately: no further beats are issued, no response is produced, and SRAM contents already written stay written.

States: IDLE, ACCESS, RESP.
- IDLE: req_ready = 1. On req_valid & req_ready, latch we, addr, wdata and wstrb; clear beat counter; go to ACCESS.
- ACCESS: one beat per cycle, beat = 0..BYTES-1.
  - sram_a = {addr_q, beat}.
  - After beat BYTES-1, go to RESP.
- RESP: rsp_valid = 1 for exactly one cycle; all SRAM controls deasserted (this is the bus turnaround/deselect cycle); go to IDLE.

Write beat:
- If wstrb_q[beat] = 1: ce_n = 0, we_n = 0, oe_n = 1, io_oe = 1, io_out = wdata_q[8*beat+7 : 8*beat]. The SRAM captures at the next posedge.
- If wstrb_q[beat] = 0: ce_n = 1, we_n = 1, io_oe = 0. The beat is still consumed, so timing is fixed.

Read beat:
- ce_n = 0, oe_n = 0, we_n = 1, io_oe = 0.
- At the end-of-cycle posedge, io_in is stored into rdata_q[8*beat+7 : 8*beat].
- rsp_rdata = rdata_q, held stable until the next read completes.

Timing and ordering:
- Latency: accept at cycle N; beats at N+1..N+BYTES; rsp_valid at N+BYTES+1; next accept no earlier than N+BYTES+2 (6-cycle period at DW = 32).
- Write with wstrb = 0 runs the full sequence, never asserts ce_n, and still acks.
- io_oe and sram_oe_n are never simultaneously active (no contention). we_n = 0 implies ce_n = 0.
- Control outputs are registered (glitch-free).
- Address wrap: the top word maps to byte addresses 0x7FFC..0x7FFF; there is no carry beyond AW.
- Requests arriving while req_ready = 0 are ignored; the requester holds them.
- req_* inputs are sampled only on accept; later changes have no effect.

Decomposition:
- Package sram_pkg: state enum (IDLE/ACCESS/RESP), BYTES and beat-width constants, SRAM control polarity constants.
- No sub-module required; the beat counter and the byte-lane mux stay inline.

Test Plan:
1. Write addr 0x0010, data 0xDEADBEEF, strb 0xF.
   - Expect bytes 0x0040 = EF, 0x0041 = BE, 0x0042 = AD, 0x0043 = DE.
   - rsp_valid exactly 5 cycles after accept.
2. Read back addr 0x0010 → rsp_rdata = 0xDEADBEEF. Check oe_n low on all 4 beats and io_oe low throughout.
3. Write addr 0x0010, data 0x11223344, strb 0x5, then read → 0xDE22BE44. Check ce_n high on beats 1 and 3.
4. Back-to-back: write then read with req_valid held high → second accept on the cycle after the RESP pulse. Check io_oe never overlaps oe_n = 0.
5. Top address 0x1FFF: write 0xA5A5A5A5, read back. Check sram_a = 0x7FFC..0x7FFF and that 0x0000 is untouched.
6. Assert rst_n low during beat 2 of a write.
   - Controls go high asynchronously; no rsp_valid.
   - Bytes 0–1 written, bytes 2–3 unchanged; req_ready = 1 after release.
